snax_alu_reducer: RTL

- Downstream consumer of the SNAX ALU processing-element result stream (c_o / c_valid_o / c_ready_i).
- Reduces a configured number of consecutive results into one word: signed sum, signed max, signed min, or last value.
- Emits the reduced word on a valid/ready output toward the streamer/TCDM write path.
- Drives the PE's c_ready_i through in_ready_o.

---
 rtl/snax_alu_reducer_pkg.sv | 17 +
 rtl/snax_alu_reducer_if.sv | 23 ++
 rtl/snax_alu_reduce_op.sv | 34 +++
 rtl/snax_alu_reducer.sv | 116 +++++++++++
 4 files changed

// File: rtl/snax_alu_reducer_pkg.sv
// Shared types for the SNAX ALU result reducer.
package snax_alu_pkg;

  typedef enum logic [1:0] {
    RED_SUM  = 2'd0,
    RED_MAX  = 2'd1,
    RED_MIN  = 2'd2,
    RED_LAST = 2'd3
  } red_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } red_state_e;

endpackage

// File: rtl/snax_alu_reducer_if.sv
// Input result stream (from the ALU PE) and reduced output stream.
interface snax_alu_reducer_if #(
  parameter int unsigned DataWidth = 64
);
  logic [DataWidth-1:0] in_data_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [DataWidth-1:0] out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;

  // Reducer side.
  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o
  );

  // PE / downstream side.
  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o
  );
endinterface

// File: rtl/snax_alu_reduce_op.sv
// Combinational reduction step: next = op(acc, in), plus signed-add overflow.
module snax_alu_reduce_op
  import snax_alu_pkg::*;
#(
  parameter int unsigned DataWidth = 64
) (
  input  logic [DataWidth-1:0] acc_i,
  input  logic [DataWidth-1:0] in_i,
  input  red_mode_e            mode_i,
  output logic [DataWidth-1:0] next_o,
  output logic                 ovf_o
);

  logic [DataWidth-1:0] sum;
  assign sum = acc_i + in_i;

  // Select the reduction result; overflow only meaningful for SUM.
  always_comb begin
    next_o = acc_i;
    ovf_o  = 1'b0;
    unique case (mode_i)
      RED_SUM: begin
        next_o = sum;
        ovf_o  = (acc_i[DataWidth-1] == in_i[DataWidth-1]) &&
                 (sum[DataWidth-1] != acc_i[DataWidth-1]);
      end
      RED_MAX:  if ($signed(in_i) > $signed(acc_i)) next_o = in_i;
      RED_MIN:  if ($signed(in_i) < $signed(acc_i)) next_o = in_i;
      RED_LAST: next_o = in_i;
      default:  next_o = acc_i;
    endcase
  end

endmodule

// File: rtl/snax_alu_reducer.sv
// Reduces a configured number of PE results into one word (SUM/MAX/MIN/LAST).
module snax_alu_reducer
  import snax_alu_pkg::*;
#(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  snax_alu_reducer_if.slave   io,
  input  logic [CntWidth-1:0] cfg_len_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                ovf_o
);

  red_state_e           state_q, state_d;
  red_mode_e            mode_q, mode_d;
  logic [CntWidth-1:0]  len_q, len_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [DataWidth-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;

  logic [DataWidth-1:0] op_next;
  logic                 op_ovf;
  logic                 in_hs;

  snax_alu_reduce_op #(
    .DataWidth (DataWidth)
  ) u_op (
    .acc_i  (acc_q),
    .in_i   (io.in_data_i),
    .mode_i (mode_q),
    .next_o (op_next),
    .ovf_o  (op_ovf)
  );

  assign in_hs          = (state_q == ST_ACCUM) && io.in_valid_i;
  assign io.in_ready_o  = (state_q == ST_ACCUM);
  assign io.out_valid_o = (state_q == ST_OUTPUT);
  assign io.out_data_o  = (state_q == ST_OUTPUT) ? acc_q : '0;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = done_q;
  assign ovf_o          = ovf_q;

  // Next-state, counter and accumulator update.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ovf_d = 1'b0;
          if (cfg_len_i != '0) begin
            len_d   = cfg_len_i;
            mode_d  = red_mode_e'(cfg_mode_i);
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (in_hs) begin
          // First word seeds the accumulator; the op only combines later words.
          if (cnt_q == '0) begin
            acc_d = io.in_data_i;
          end else begin
            acc_d = op_next;
            if (mode_q == RED_SUM && op_ovf) ovf_d = 1'b1;
          end
          cnt_d = cnt_q + CntWidth'(1);
          if (cnt_q == len_q - CntWidth'(1)) state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (io.out_ready_i) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset discarding any partial result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= RED_SUM;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

endmodule
